// File: rtl/core_pkg.sv
// Shared core definitions.
// pipe_state_e : fill state of an elastic pipeline stage.
// occ_of_state : number of payload entries held in a given state.
package core_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } pipe_state_e;

  function automatic logic [1:0] occ_of_state(input pipe_state_e s);
    case (s)
      PS_FULL: return 2'd1;
      PS_SKID: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Payload holding register for one pipeline slot.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, clears the payload
//   clr_i - synchronous clear (honoured only when CLEAR_ON_FLUSH != 0)
//   ld_i  - load enable; the payload is held whenever it is low
//   d_i   - next payload
//   q_o   - held payload
module pipe_payload_reg #(
  parameter int PAYLOAD_W      = 32,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 ld_i,
  input  logic [PAYLOAD_W-1:0] d_i,
  output logic [PAYLOAD_W-1:0] q_o
);

  logic [PAYLOAD_W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (clr_i && (CLEAR_ON_FLUSH != 0)) begin
      data_q <= '0;
    end else if (ld_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with valid/ready handshake, flush-to-bubble and an
// optional skid slot so that in_ready is a pure flop output when SKID_EN=1.
// Ports:
//   clk, rst            - clock and asynchronous active-high reset
//   flush               - discard all held entries at the next edge
//   in_valid/in_ready   - upstream handshake, in_data is the payload
//   out_valid/out_ready - downstream handshake, out_data is the head payload
//   occupancy           - entries held (0..2)
//   stall_cycles        - saturating count of cycles with out_valid && !out_ready
module pipe_skid_stage
  import core_pkg::*;
#(
  parameter int PAYLOAD_W      = 32,
  parameter int SKID_EN        = 1,
  parameter int CLEAR_ON_FLUSH = 1,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cycles
);

  pipe_state_e          state_q, state_d;
  logic [1:0]           occ_q;
  logic [CNT_W-1:0]     stall_q;
  logic                 in_fire, out_fire;
  logic                 main_ld, main_from_skid, skid_ld;
  logic [PAYLOAD_W-1:0] main_q, main_d, skid_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // State register, occupancy and stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PS_EMPTY;
      occ_q   <= 2'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_of_state(state_d);
      if (out_valid && !out_ready) begin
        stall_q <= sat_inc(stall_q);
      end
    end
  end

  // Handshake outputs. Without a skid slot a full stage can only accept when
  // the head leaves this cycle, so out_ready passes straight to in_ready.
  always_comb begin
    out_valid = (state_q != PS_EMPTY);
    if (SKID_EN != 0) begin
      in_ready = (state_q != PS_SKID);
    end else begin
      in_ready = (state_q == PS_EMPTY) || out_ready;
    end
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Next state and slot load enables; flush wins over every transfer.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (flush) begin
      state_d = PS_EMPTY;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            state_d = PS_FULL;
            main_ld = 1'b1;
          end
        end
        PS_FULL: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
          end else if (in_fire && (SKID_EN != 0)) begin
            state_d = PS_SKID;
            skid_ld = 1'b1;
          end else if (out_fire) begin
            state_d = PS_EMPTY;
          end
        end
        PS_SKID: begin
          if (out_fire) begin
            state_d        = PS_FULL;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  pipe_payload_reg #(
    .PAYLOAD_W      (PAYLOAD_W),
    .CLEAR_ON_FLUSH (CLEAR_ON_FLUSH)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .ld_i  (main_ld),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  generate
    if (SKID_EN != 0) begin : g_skid
      pipe_payload_reg #(
        .PAYLOAD_W      (PAYLOAD_W),
        .CLEAR_ON_FLUSH (CLEAR_ON_FLUSH)
      ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .ld_i  (skid_ld),
        .d_i   (in_data),
        .q_o   (skid_q)
      );
    end else begin : g_no_skid
      logic unused_skid_ld;
      assign unused_skid_ld = skid_ld;
      assign skid_q         = '0;
    end
  endgenerate

  assign out_data     = main_q;
  assign occupancy    = occ_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  localparam int PW = 16;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, in_valid, out_ready;
  logic [PW-1:0] in_data;

  logic          a_in_ready, a_out_valid;
  logic [PW-1:0] a_out_data;
  logic [1:0]    a_occ;
  logic [CW-1:0] a_stall;
  logic          b_in_ready, b_out_valid;
  logic [PW-1:0] b_out_data;
  logic [1:0]    b_occ;
  logic [CW-1:0] b_stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Skid buffer, clearing payloads on flush
  pipe_skid_stage #(.PAYLOAD_W(PW), .SKID_EN(1), .CLEAR_ON_FLUSH(1), .CNT_W(CW)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .occupancy(a_occ), .stall_cycles(a_stall));

  // Single entry, payload kept on flush
  pipe_skid_stage #(.PAYLOAD_W(PW), .SKID_EN(0), .CLEAR_ON_FLUSH(0), .CNT_W(CW)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .occupancy(b_occ), .stall_cycles(b_stall));

  // Reference model: a FIFO of at most cap entries (e0 is the head), the last
  // head value seen on out_data, and a saturating stall count.
  typedef struct {
    int          n;
    logic [PW-1:0] e0;
    logic [PW-1:0] e1;
    logic [PW-1:0] shadow;
    int          stall;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t m_reset();
    mdl_t m;
    m.n = 0; m.e0 = '0; m.e1 = '0; m.shadow = '0; m.stall = 0;
    return m;
  endfunction

  function automatic bit m_ready(mdl_t m, bit skid, bit ordy);
    if (skid) return (m.n < 2);
    return (m.n == 0) || ordy;
  endfunction

  function automatic mdl_t m_next(mdl_t m, bit skid, bit clr, bit fl, bit iv,
                                  logic [PW-1:0] id, bit ordy);
    bit inf, outf;
    inf  = iv && m_ready(m, skid, ordy);
    outf = (m.n > 0) && ordy;
    if (m.n > 0 && !ordy && m.stall < SAT) m.stall++;
    if (fl) begin
      m.n = 0;
      if (clr) m.shadow = '0;
    end else begin
      if (outf) begin
        m.e0 = m.e1;
        m.n--;
      end
      if (inf) begin
        if (m.n == 0) m.e0 = id;
        else m.e1 = id;
        m.n++;
      end
      if (m.n > 0) m.shadow = m.e0;
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_out_valid", 32'(a_out_valid), 32'(ma.n > 0));
    chk("a_out_data",  32'(a_out_data),  32'(ma.shadow));
    chk("a_in_ready",  32'(a_in_ready),  32'(m_ready(ma, 1'b1, out_ready)));
    chk("a_occupancy", 32'(a_occ),       32'(ma.n));
    chk("a_stall",     32'(a_stall),     32'(ma.stall));
    chk("b_out_valid", 32'(b_out_valid), 32'(mb.n > 0));
    chk("b_out_data",  32'(b_out_data),  32'(mb.shadow));
    chk("b_in_ready",  32'(b_in_ready),  32'(m_ready(mb, 1'b0, out_ready)));
    chk("b_occupancy", 32'(b_occ),       32'(mb.n));
    chk("b_stall",     32'(b_stall),     32'(mb.stall));
  endtask

  // Check outputs mid-cycle, then advance the model across the rising edge.
  task automatic cycle();
    mdl_t na, nb;
    @(negedge clk);
    check_all();
    if (rst) begin
      na = m_reset();
      nb = m_reset();
    end else begin
      na = m_next(ma, 1'b1, 1'b1, flush, in_valid, in_data, out_ready);
      nb = m_next(mb, 1'b0, 1'b0, flush, in_valid, in_data, out_ready);
    end
    @(posedge clk);
    #1;
    ma = na;
    mb = nb;
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [PW-1:0] d, input logic ordy);
    flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  initial begin
    ma = m_reset();
    mb = m_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0);

    // Reset state
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Streaming 1..4 with downstream always ready
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b1, PW'(k), 1'b1);
      cycle();
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    cycle();
    cycle();
    chk("stream_no_stall", 32'(a_stall), 32'd0);

    // Stall into the skid slot, then drain in order
    drive(1'b0, 1'b1, 16'h000A, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 16'h000B, 1'b0);
    cycle();
    chk("skid_full_occ", 32'(a_occ), 32'd2);
    chk("skid_full_rdy", 32'(a_in_ready), 32'd0);
    chk("noskid_stall_rdy", 32'(b_in_ready), 32'd0);
    drive(1'b0, 1'b1, 16'h000C, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 16'h000C, 1'b1);
    cycle();
    chk("drain_head_b", 32'(a_out_data), 32'h000B);
    cycle();
    chk("drain_head_c", 32'(a_out_data), 32'h000C);
    drive(1'b0, 1'b0, '0, 1'b1);
    cycle();
    cycle();

    // Flush with two entries held and a same-cycle offer that must be dropped
    drive(1'b0, 1'b1, 16'h0011, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 16'h0022, 1'b0);
    cycle();
    drive(1'b1, 1'b1, 16'h0055, 1'b0);
    cycle();
    drive(1'b0, 1'b0, '0, 1'b1);
    chk("flush_valid", 32'(a_out_valid), 32'd0);
    chk("flush_clear", 32'(a_out_data), 32'd0);
    chk("flush_keep_b", 32'(b_out_data), 32'h0011);
    cycle();
    cycle();

    // Stall counter saturation, unaffected by flush
    drive(1'b0, 1'b1, 16'h0077, 1'b1);
    cycle();
    drive(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_a", 32'(a_stall), SAT);
    drive(1'b1, 1'b0, '0, 1'b0);
    cycle();
    drive(1'b0, 1'b0, '0, 1'b1);
    cycle();
    chk("sat_after_flush", 32'(a_stall), SAT);

    // Single-entry stage: replace head every cycle
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, PW'(16'h0100 + k), 1'b1);
      cycle();
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    cycle();

    // Asynchronous reset while the skid stage holds two entries
    drive(1'b0, 1'b1, 16'h00E1, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 16'h00E2, 1'b0);
    cycle();
    chk("pre_rst_occ", 32'(a_occ), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    ma = m_reset();
    mb = m_reset();
    chk("rst_valid",  32'(a_out_valid), 32'd0);
    chk("rst_occ",    32'(a_occ), 32'd0);
    chk("rst_stall",  32'(a_stall), 32'd0);
    chk("rst_data",   32'(a_out_data), 32'd0);
    chk("rst_ready",  32'(a_in_ready), 32'd1);
    chk("rst_b_data", 32'(b_out_data), 32'd0);
    drive(1'b0, 1'b0, '0, 1'b0);
    cycle();
    rst = 1'b0;
    cycle();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 16) == 0, ($urandom % 2) == 0, PW'($urandom), ($urandom % 3) != 0);
      cycle();
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
